// File: rtl/multi_debouncer_if.sv
// Button/debounce bus for multi_debouncer: raw button levels in, debounced
// levels and one-tick event pulses out.
interface multi_debouncer_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] button;
    logic [CHANNELS-1:0] out_state;
    logic [CHANNELS-1:0] press_pulse;
    logic [CHANNELS-1:0] release_pulse;
    logic [CHANNELS-1:0] long_press;

    modport master (
        output button,
        input  out_state,
        input  press_pulse,
        input  release_pulse,
        input  long_press
    );

    modport slave (
        input  button,
        output out_state,
        output press_pulse,
        output release_pulse,
        output long_press
    );
endinterface

// File: rtl/multi_debouncer.sv
// Multi-channel push-button debouncer: 2-flop sync, symmetric integrator, press/release pulses.
// Optional long-press detection when MULTI_DEBOUNCER_LONG_PRESS_EN is defined.
module multi_debouncer #(
    parameter int CHANNELS   = 4,
    parameter int SAMPLES    = 9,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_TICKS = 500
) (
    input  logic                  clk_from_divider,
    input  logic                  rst_n,
    multi_debouncer_if.slave      bus
);

    localparam int CW = $clog2(SAMPLES + 1);

    generate
        if (SAMPLES < 2 || CHANNELS < 1 || LONG_TICKS <= SAMPLES) begin : g_bad_cfg
            $fatal(1, "multi_debouncer: illegal SAMPLES/CHANNELS/LONG_TICKS combination");
        end
    endgenerate

    logic [CHANNELS-1:0] lvl;
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CHANNELS-1:0] out_state_q, out_state_d;
    logic [CHANNELS-1:0] press_pulse_q, press_pulse_d;
    logic [CHANNELS-1:0] release_pulse_q, release_pulse_d;
    logic [CHANNELS-1:0] flip;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];

    always_comb begin
        lvl     = (ACTIVE_LOW != 0) ? ~bus.button : bus.button;
        sync1_d = lvl;
        sync2_d = sync1_q;
    end

    // Any sample agreeing with the debounced level restarts the count.
    always_comb begin
        flip = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != out_state_q[i]) begin
                if (cnt_q[i] == CW'(SAMPLES - 1)) begin
                    flip[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        out_state_d     = out_state_q ^ flip;
        press_pulse_d   = flip & ~out_state_q;
        release_pulse_d = flip & out_state_q;
    end

    always_ff @(posedge clk_from_divider or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            out_state_q     <= '0;
            press_pulse_q   <= '0;
            release_pulse_q <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            out_state_q     <= out_state_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.out_state     = out_state_q;
    assign bus.press_pulse   = press_pulse_q;
    assign bus.release_pulse = release_pulse_q;

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
    localparam logic [15:0] LONG_LIM = 16'(LONG_TICKS);

    logic [15:0]         hold_q [CHANNELS];
    logic [15:0]         hold_d [CHANNELS];
    logic [CHANNELS-1:0] fired_q, fired_d;
    logic [CHANNELS-1:0] long_press_q, long_press_d;

    // Hold counter saturates at LONG_LIM; the fired flag blocks repeats until release.
    always_comb begin
        fired_d      = '0;
        long_press_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            hold_d[i] = '0;
            if (out_state_q[i]) begin
                hold_d[i]       = (hold_q[i] == LONG_LIM) ? hold_q[i] : hold_q[i] + 16'd1;
                long_press_d[i] = (hold_q[i] == LONG_LIM - 16'd1) && !fired_q[i];
                fired_d[i]      = fired_q[i] | long_press_d[i];
            end
        end
    end

    always_ff @(posedge clk_from_divider or negedge rst_n) begin
        if (!rst_n) begin
            fired_q      <= '0;
            long_press_q <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            fired_q      <= fired_d;
            long_press_q <= long_press_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign bus.long_press = long_press_q;
`else
    assign bus.long_press = '0;
`endif

    a_pulse_exclusive: assert property (
        @(posedge clk_from_divider) disable iff (!rst_n)
        (press_pulse_q & release_pulse_q) == '0
    );

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: vector table, directed corner sequences and
// randomized stimulus against a sliding-window reference model (active-low and active-high DUTs).
module tb_multi_debouncer;

    localparam int CH   = 4;
    localparam int SAMP = 4;
    localparam int LONG = 10;
`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] btn;
    int            n_chk  = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    multi_debouncer_if #(.CHANNELS(CH)) bus_al ();
    multi_debouncer_if #(.CHANNELS(CH)) bus_ah ();

    assign bus_al.button = btn;
    assign bus_ah.button = ~btn;

    multi_debouncer #(.CHANNELS(CH), .SAMPLES(SAMP), .ACTIVE_LOW(1), .LONG_TICKS(LONG)) dut_al (
        .clk_from_divider(clk),
        .rst_n           (rst_n),
        .bus             (bus_al)
    );

    multi_debouncer #(.CHANNELS(CH), .SAMPLES(SAMP), .ACTIVE_LOW(0), .LONG_TICKS(LONG)) dut_ah (
        .clk_from_divider(clk),
        .rst_n           (rst_n),
        .bus             (bus_ah)
    );

    // Reference model: a channel changes state when the last SAMP synchronised samples
    // (the pressed-level seen two edges earlier) all disagree with the current state.
    logic [CH-1:0] m_state, m_press, m_rel, m_long;
    logic [SAMP:0] m_hist [CH];
    int            m_edge;
    int            m_rise [CH];

    function automatic logic flips(input logic [SAMP:0] h, input logic s);
        return h[SAMP:1] == {SAMP{~s}};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= '0;
            m_press <= '0;
            m_rel   <= '0;
            m_long  <= '0;
            m_edge  <= 0;
            for (int c = 0; c < CH; c++) begin
                m_hist[c] <= '0;
                m_rise[c] <= 0;
            end
        end else begin
            m_edge <= m_edge + 1;
            for (int c = 0; c < CH; c++) begin
                m_state[c] <= m_state[c] ^ flips(m_hist[c], m_state[c]);
                m_press[c] <= flips(m_hist[c], m_state[c]) & ~m_state[c];
                m_rel[c]   <= flips(m_hist[c], m_state[c]) & m_state[c];
                m_long[c]  <= LP_EN && m_state[c] && ((m_edge + 1 - m_rise[c]) == LONG);
                if (flips(m_hist[c], m_state[c]) && !m_state[c]) m_rise[c] <= m_edge + 1;
                m_hist[c]  <= {m_hist[c][SAMP-1:0], ~btn[c]};
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_check();
        chk("al_out_state", 32'(bus_al.out_state),     32'(m_state));
        chk("al_press",     32'(bus_al.press_pulse),   32'(m_press));
        chk("al_release",   32'(bus_al.release_pulse), 32'(m_rel));
        chk("al_long",      32'(bus_al.long_press),    32'(m_long));
        chk("ah_out_state", 32'(bus_ah.out_state),     32'(m_state));
        chk("ah_press",     32'(bus_ah.press_pulse),   32'(m_press));
        chk("ah_release",   32'(bus_ah.release_pulse), 32'(m_rel));
        chk("ah_long",      32'(bus_ah.long_press),    32'(m_long));
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic tick(input logic [CH-1:0] b);
        btn = b;
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        logic [CH-1:0] b;
        logic [CH-1:0] st;
        logic [CH-1:0] pp;
        logic [CH-1:0] rp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [CH-1:0] b, st, pp, rp, input int n);
        vec_t v;
        v.b = b; v.st = st; v.pp = pp; v.rp = rp;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nrel, rel_at, rise, lt, nlong, rate;
        logic [CH-1:0] b;

        // Rows start at the first edge after reset release; all buttons held pressed.
        add(4'b0000, 4'h0, 4'h0, 4'h0, 5);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 1);
        add(4'b0000, 4'hF, 4'h0, 4'h0, 1);
        add(4'b1111, 4'hF, 4'h0, 4'h0, 5);
        add(4'b1111, 4'h0, 4'h0, 4'hF, 1);
        add(4'b1111, 4'h0, 4'h0, 4'h0, 1);
        // clean press on channel 0
        add(4'b1110, 4'h0, 4'h0, 4'h0, 5);
        add(4'b1110, 4'h1, 4'h1, 4'h0, 1);
        add(4'b1110, 4'h1, 4'h0, 4'h0, 2);
        // 3-tick glitch on channel 1 is rejected
        add(4'b1100, 4'h1, 4'h0, 4'h0, 3);
        add(4'b1110, 4'h1, 4'h0, 4'h0, 7);
        // 4-tick press on channel 1 is accepted, then released
        add(4'b1100, 4'h1, 4'h0, 4'h0, 4);
        add(4'b1110, 4'h1, 4'h0, 4'h0, 1);
        add(4'b1110, 4'h3, 4'h2, 4'h0, 1);
        add(4'b1110, 4'h3, 4'h0, 4'h0, 3);
        add(4'b1110, 4'h1, 4'h0, 4'h2, 1);
        add(4'b1110, 4'h1, 4'h0, 4'h0, 1);
        add(4'b1111, 4'h1, 4'h0, 4'h0, 5);
        add(4'b1111, 4'h0, 4'h0, 4'h1, 1);
        // channels 0 and 3 together
        add(4'b0110, 4'h0, 4'h0, 4'h0, 5);
        add(4'b0110, 4'h9, 4'h9, 4'h0, 1);
        add(4'b0110, 4'h9, 4'h0, 4'h0, 1);
        add(4'b1111, 4'h9, 4'h0, 4'h0, 5);
        add(4'b1111, 4'h0, 4'h0, 4'h9, 1);
        add(4'b1111, 4'h0, 4'h0, 4'h0, 1);

        rst_n = 1'b0;
        btn   = 4'b0000;
        repeat (3) begin
            tick(4'b0000);
            chk("reset_state", 32'(bus_al.out_state), 32'h0);
            chk("reset_pulses", 32'({bus_al.press_pulse, bus_al.release_pulse, bus_al.long_press}), 32'h0);
        end
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            tick(tbl[i].b);
            chk($sformatf("tbl%0d_state", i),   32'(bus_al.out_state),     32'(tbl[i].st));
            chk($sformatf("tbl%0d_press", i),   32'(bus_al.press_pulse),   32'(tbl[i].pp));
            chk($sformatf("tbl%0d_release", i), 32'(bus_al.release_pulse), 32'(tbl[i].rp));
            chk($sformatf("tbl%0d_ah_state", i), 32'(bus_ah.out_state),    32'(tbl[i].st));
        end

        // Release bounce on channel 2
        repeat (8) tick(4'b1011);
        chk("bounce_pressed", 32'(bus_al.out_state), 32'h4);
        nrel = 0;
        for (int t = 0; t < 20; t++) begin
            tick((t % 2 == 0) ? 4'b1111 : 4'b1011);
            nrel += int'(bus_al.release_pulse[2]);
        end
        rel_at = -1;
        for (int j = 0; j < 12; j++) begin
            tick(4'b1111);
            if (bus_al.release_pulse[2]) begin
                nrel++;
                rel_at = j;
            end
        end
        chk("bounce_release_count", 32'(nrel), 32'd1);
        chk("bounce_release_offset", 32'(rel_at), 32'd5);

        // Long hold on channel 1
        rise = -1; lt = -1; nlong = 0;
        for (int t = 0; t < 35; t++) begin
            tick(4'b1101);
            if (bus_al.out_state[1] && rise < 0) rise = t;
            if (bus_al.long_press != '0) begin
                nlong++;
                lt = t;
            end
        end
        chk("long_rise_offset", 32'(rise), 32'd5);
        chk("long_count", 32'(nlong), LP_EN ? 32'd1 : 32'd0);
        chk("long_offset", 32'(lt), LP_EN ? 32'd15 : 32'hFFFF_FFFF);
        nrel = 0;
        repeat (8) begin
            tick(4'b1111);
            nrel += int'(bus_al.release_pulse[1]);
        end
        chk("long_release_count", 32'(nrel), 32'd1);

        // Randomized phase with a mid-operation asynchronous reset
        b = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            rate = ((i / 100) % 2 == 1) ? 12 : 4;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, rate) == 0) b[c] = ~b[c];
            end
            if (i == 300) begin
                #3 rst_n = 1'b0;
                #1 model_check();
                chk("midreset_state", 32'(bus_al.out_state), 32'h0);
                @(negedge clk);
                tick(b);
                rst_n = 1'b1;
            end
            tick(b);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
